// File: rtl/imm_gen_if.sv
// rtl/imm_gen_if.sv - handshake bundle between decode and the registered immediate generator
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_imm;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, in_imm, in_sel, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_imm, in_sel, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate extender behind a 2-entry skid buffer
// Defining IMMGEN_ZICSR_EN makes in_sel=101 a legal zero-extended CSR uimm format.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input logic     clk,
  input logic     rst_n,
  imm_gen_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_J = 3'b011;
  localparam logic [2:0] SEL_U = 3'b100;
  localparam logic [2:0] SEL_Z = 3'b101;

`ifdef IMMGEN_ZICSR_EN
  localparam bit ZICSR_EN = 1'b1;
`else
  localparam bit ZICSR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       count;
  logic [XLEN-1:0]  e0_imm, e1_imm;
  logic [TAG_W-1:0] e0_tag, e1_tag;
  logic             e0_ill, e1_ill;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      ext32;
  logic             ext_ill;
  logic [XLEN-1:0]  ext_imm;
  logic             s;
  logic             can_accept, has_head, push, pop;

  assign s = bus.in_imm[24];

  // Bit 31 of ext32 is always the correct fill bit for the upper half:
  // the sign for I/S/B/J/U, and zero for Z and illegal beats.
  always_comb begin
    ext32   = '0;
    ext_ill = 1'b0;
    case (bus.in_sel)
      SEL_I: ext32 = {{20{s}}, bus.in_imm[24:13]};
      SEL_S: ext32 = {{20{s}}, bus.in_imm[24:18], bus.in_imm[4:0]};
      SEL_B: ext32 = {{20{s}}, bus.in_imm[0], bus.in_imm[23:18], bus.in_imm[4:1], 1'b0};
      SEL_J: ext32 = {{12{s}}, bus.in_imm[12:5], bus.in_imm[13], bus.in_imm[23:14], 1'b0};
      SEL_U: ext32 = {bus.in_imm[24:5], 12'b0};
      SEL_Z: begin
        if (ZICSR_EN) ext32   = {27'b0, bus.in_imm[12:8]};
        else          ext_ill = 1'b1;
      end
      default: ext_ill = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign ext_imm = {{(XLEN-32){ext32[31]}}, ext32};
    end else begin : g_narrow
      assign ext_imm = ext32;
    end
  endgenerate

  assign can_accept = (count != FULL);
  assign has_head   = (count == ONE) || (count == FULL);
  assign push       = bus.in_valid & can_accept & ~bus.flush;
  assign pop        = has_head & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= EMPTY;
      e0_imm <= '0;
      e0_tag <= '0;
      e0_ill <= 1'b0;
      e1_imm <= '0;
      e1_tag <= '0;
      e1_ill <= 1'b0;
    end else if (bus.flush) begin
      count <= EMPTY;
    end else begin
      case (count)
        EMPTY: begin
          if (push) begin
            e0_imm <= ext_imm;
            e0_tag <= bus.in_tag;
            e0_ill <= ext_ill;
            count  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            e0_imm <= ext_imm;
            e0_tag <= bus.in_tag;
            e0_ill <= ext_ill;
          end else if (push) begin
            e1_imm <= ext_imm;
            e1_tag <= bus.in_tag;
            e1_ill <= ext_ill;
            count  <= FULL;
          end else if (pop) begin
            count <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            e0_imm <= e1_imm;
            e0_tag <= e1_tag;
            e0_ill <= e1_ill;
            count  <= ONE;
          end
        end
        default: count <= EMPTY;
      endcase
    end
  end

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && ext_ill && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready    = can_accept;
  assign bus.out_valid   = has_head;
  assign bus.out_imm     = e0_imm;
  assign bus.out_tag     = e0_tag;
  assign bus.out_illegal = e0_ill;
  assign bus.illegal_cnt = cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (honours IMMGEN_ZICSR_EN)
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;
  localparam int CNT_W = 8;
  localparam int NVEC  = 7;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  typedef struct {
    logic [31:0]      instr;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_imm;
    logic             exp_ill;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t q[$];
  exp_t last;
  int   mcnt;

  imm_gen_if #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus();
  imm_gen_if #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus64();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64.slave)
  );

  always #5 clk = ~clk;

  // Reference: rebuild the full instruction word and apply the standard RISC-V immediate layouts.
  function automatic exp_t model(input logic [31:0] instr, input logic [2:0] sel,
                                 input logic [TAG_W-1:0] tag, input int xlen);
    exp_t   e;
    longint v;
    e.tag = tag;
    e.ill = 1'b0;
    v     = 0;
    case (sel)
      3'd0: begin v = longint'(instr[31:20]); if (instr[31]) v -= longint'(1) << 12; end
      3'd1: begin v = longint'({instr[31:25], instr[11:7]}); if (instr[31]) v -= longint'(1) << 12; end
      3'd2: begin
        v = longint'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        if (instr[31]) v -= longint'(1) << 13;
      end
      3'd3: begin
        v = longint'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
        if (instr[31]) v -= longint'(1) << 21;
      end
      3'd4: begin v = longint'(instr[31:12]) * 4096; if (instr[31]) v -= longint'(1) << 32; end
`ifdef IMMGEN_ZICSR_EN
      3'd5: v = longint'(instr[19:15]);
`endif
      default: e.ill = 1'b1;
    endcase
    e.imm = (xlen == 32) ? {32'h0, v[31:0]} : 64'(v);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string nm);
    exp_t h;
    h = (q.size() > 0) ? q[0] : last;
    chk({nm, ".in_ready"},    64'(bus.in_ready),    64'(q.size() < 2));
    chk({nm, ".out_valid"},   64'(bus.out_valid),   64'(q.size() > 0));
    chk({nm, ".out_imm"},     64'(bus.out_imm),     h.imm);
    chk({nm, ".out_tag"},     64'(bus.out_tag),     64'(h.tag));
    chk({nm, ".out_illegal"}, 64'(bus.out_illegal), 64'(h.ill));
    chk({nm, ".illegal_cnt"}, 64'(bus.illegal_cnt), 64'(mcnt));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input string nm, input logic v, input logic [31:0] instr, input logic [2:0] sel,
                      input logic [TAG_W-1:0] tag, input logic fl, input logic rdy);
    logic push, pop;
    exp_t e;
    bus.in_valid  = v;
    bus.in_imm    = instr[31:7];
    bus.in_sel    = sel;
    bus.in_tag    = tag;
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    check_outputs(nm);
    push = v && (q.size() < 2) && !fl;
    pop  = (q.size() > 0) && rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e = model(instr, sel, tag, 32);
        q.push_back(e);
        if (e.ill && mcnt < (1 << CNT_W) - 1) mcnt++;
      end
    end
    if (q.size() > 0) last = q[0];
  endtask

  task automatic idle(input string nm, input logic rdy);
    step(nm, 1'b0, 32'h0, 3'd0, '0, 1'b0, rdy);
  endtask

  vec_t vt[NVEC];
  exp_t e64;

  initial begin
    vt[0] = '{32'hFFF00093, 3'd0, 5'd1,  32'hFFFFFFFF, 1'b0};
    vt[1] = '{32'hFE512E23, 3'd1, 5'd2,  32'hFFFFFFFC, 1'b0};
    vt[2] = '{32'hFE000EE3, 3'd2, 5'd3,  32'hFFFFFFFC, 1'b0};
    vt[3] = '{32'h0010006F, 3'd3, 5'd4,  32'h00000800, 1'b0};
    vt[4] = '{32'h123452B7, 3'd4, 5'd5,  32'h12345000, 1'b0};
    vt[5] = '{32'h12345678, 3'd7, 5'd6,  32'h00000000, 1'b1};
`ifdef IMMGEN_ZICSR_EN
    vt[6] = '{32'h340FD073, 3'd5, 5'd31, 32'h0000001F, 1'b0};
`else
    vt[6] = '{32'h340FD073, 3'd5, 5'd31, 32'h00000000, 1'b1};
`endif

    q.delete();
    last = '{64'h0, '0, 1'b0};
    mcnt = 0;
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_sel = '0; bus.in_tag = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_imm = '0; bus64.in_sel = '0; bus64.in_tag = '0;
    bus64.flush = 1'b0; bus64.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1 check_outputs("reset");
    chk("reset.out_imm64", 64'(bus64.out_imm), 64'h0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("post_reset", 1'b1);

    // Back-to-back stream, one new head per cycle
    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("tbl%0d", i), 1'b1, vt[i].instr, vt[i].sel, vt[i].tag, 1'b0, 1'b1);
      chk($sformatf("tbl%0d.valid", i),   64'(bus.out_valid),   64'h1);
      chk($sformatf("tbl%0d.imm", i),     64'(bus.out_imm),     64'(vt[i].exp_imm));
      chk($sformatf("tbl%0d.tag", i),     64'(bus.out_tag),     64'(vt[i].tag));
      chk($sformatf("tbl%0d.illegal", i), 64'(bus.out_illegal), 64'(vt[i].exp_ill));
    end
    idle("tbl_drain", 1'b1);

    // XLEN=64 sign fill for U and I formats
    bus64.in_valid = 1'b1; bus64.in_imm = 25'(32'h800000B7 >> 7); bus64.in_sel = 3'd4; bus64.in_tag = 5'd9;
    @(posedge clk); #1;
    bus64.in_imm = 25'(32'hFFF00093 >> 7); bus64.in_sel = 3'd0; bus64.in_tag = 5'd10;
    chk("x64.u.valid", 64'(bus64.out_valid), 64'h1);
    chk("x64.u.imm",   bus64.out_imm, 64'hFFFFFFFF80000000);
    e64 = model(32'h800000B7, 3'd4, 5'd9, 64);
    chk("x64.u.model", bus64.out_imm, e64.imm);
    chk("x64.u.tag",   64'(bus64.out_tag), 64'd9);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    chk("x64.i.imm",   bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);

    // Backpressure: third beat refused, drain in order
    step("bp0", 1'b1, 32'h00100093, 3'd0, 5'd11, 1'b0, 1'b0);
    step("bp1", 1'b1, 32'h00200093, 3'd0, 5'd12, 1'b0, 1'b0);
    chk("bp.in_ready_full", 64'(bus.in_ready), 64'h0);
    step("bp2", 1'b1, 32'h00300093, 3'd0, 5'd13, 1'b0, 1'b0);
    chk("bp.head_tag", 64'(bus.out_tag), 64'd11);
    idle("bp_drain0", 1'b1);
    chk("bp.in_ready_back", 64'(bus.in_ready), 64'h1);
    chk("bp.second_tag", 64'(bus.out_tag), 64'd12);
    idle("bp_drain1", 1'b1);
    chk("bp.empty", 64'(bus.out_valid), 64'h0);
    idle("bp_drain2", 1'b1);

    // Flush while full with a beat presented: everything lost
    step("fl0", 1'b1, 32'h00400093, 3'd0, 5'd14, 1'b0, 1'b0);
    step("fl1", 1'b1, 32'h00500093, 3'd0, 5'd15, 1'b0, 1'b0);
    step("fl2", 1'b1, 32'h00600093, 3'd0, 5'd16, 1'b1, 1'b1);
    chk("fl.out_valid", 64'(bus.out_valid), 64'h0);
    chk("fl.in_ready",  64'(bus.in_ready),  64'h1);
    idle("fl_after", 1'b1);

    // Randomised traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
           TAG_W'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
    end
    idle("rnd_drain0", 1'b1);
    idle("rnd_drain1", 1'b1);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      step("sat", 1'b1, $urandom, 3'd7, TAG_W'(i), 1'b0, 1'b1);
    end
    idle("sat_drain", 1'b1);
    chk("sat.illegal_cnt", 64'(bus.illegal_cnt), 64'd255);

    // Async reset with two entries queued
    step("rs0", 1'b1, 32'h00700093, 3'd0, 5'd17, 1'b0, 1'b0);
    step("rs1", 1'b1, 32'h00800093, 3'd0, 5'd18, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.out_valid",   64'(bus.out_valid),   64'h0);
    chk("rst.out_imm",     64'(bus.out_imm),     64'h0);
    chk("rst.out_tag",     64'(bus.out_tag),     64'h0);
    chk("rst.out_illegal", 64'(bus.out_illegal), 64'h0);
    chk("rst.illegal_cnt", 64'(bus.illegal_cnt), 64'h0);
    chk("rst.out_imm64",   bus64.out_imm,        64'h0);
    q.delete();
    last = '{64'h0, '0, 1'b0};
    mcnt = 0;
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(bus.in_ready), 64'h1);
    idle("rst_after", 1'b1);
    step("rst_push", 1'b1, 32'hFFF00093, 3'd0, 5'd19, 1'b0, 1'b1);
    idle("rst_end", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
